// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI slave register file, all pins oversampled on clk.
// Frame: 8-bit command (bit7 = write, low ADDR_W bits = address), then any
// number of DATA_W-bit words, MSB first. A host write port shares the
// register array; an SPI commit to the same address on the same clk wins.
// Optional macro SPI_REGFILE_AUTOINC_EN: when defined, the address advances
// (with wrap) after every data word; otherwise it stays fixed for the frame.
module spi_regfile_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sclk,
  input  logic                             mosi,
  input  logic                             cs_n,
  output logic                             miso,
  output logic                             miso_oe,
  input  logic                             hw_we,
  input  logic [ADDR_W-1:0]                hw_addr,
  input  logic [DATA_W-1:0]                hw_wdata,
  output logic [(2**ADDR_W)*DATA_W-1:0]    regs_out,
  output logic                             wr_strobe,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic                             busy
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int RX_W     = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W    = 5;
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // Synchroniser stages: [0],[1] metastability filter, [2] edge-detect history
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [1:0] vld_q;   // marks which sync stages hold real post-reset samples

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [RX_W-2:0]     rx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W-1:0]   tx_q;
  logic                skip_q;
  logic                miso_q;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                armed_q;   // a genuine cs_n high has been seen since reset
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic              sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic              cs_sync, cs_fall, mosi_bit;
  logic [RX_W-1:0]   rx_nxt;
  logic [ADDR_W-1:0] cmd_addr, addr_nxt;
  logic              cmd_wr, cmd_end, word_end, commit, do_load;
  logic [DATA_W-1:0] load_val;
  logic              unused_rx;

  // Three-stage input synchronisers, reset to the bus idle levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= {3{CPOL}};
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
      vld_q  <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign cs_sync     = cs_q[1];
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  // mosi taken from the same stage that feeds the sclk edge detector
  assign mosi_bit    = mosi_q[1];

  assign rx_nxt   = {rx_q, mosi_bit};
  assign cmd_addr = rx_nxt[ADDR_W-1:0];
  assign cmd_wr   = rx_nxt[7];
  assign unused_rx = ^rx_nxt;

`ifdef SPI_REGFILE_AUTOINC_EN
  assign addr_nxt = addr_q + ADDR_W'(1);
`else
  assign addr_nxt = addr_q;
`endif

  assign cmd_end  = (state_q == ST_CMD)  && (cnt_q == CNT_W'(7));
  assign word_end = (state_q == ST_DATA) && (cnt_q == CNT_W'(DATA_W-1));
  assign commit   = ~cs_sync & sample_edge & word_end & wr_q;
  assign do_load  = ~cs_sync & sample_edge & ((cmd_end & ~cmd_wr) | (word_end & ~wr_q));
  // Read data is taken from the array as it stands when the shifter loads
  assign load_val = (state_q == ST_CMD) ? regs_q[cmd_addr] : regs_q[addr_nxt];

  // Register array: host write first, SPI commit overrides on address clash
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
    end else begin
      if (hw_we)  regs_q[hw_addr] <= hw_wdata;
      if (commit) regs_q[addr_q]  <= rx_nxt[DATA_W-1:0];
    end
  end

  // Frame FSM with bit counter, rx/tx shifters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      tx_q        <= '0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      armed_q     <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (vld_q[1] && cs_sync) armed_q <= 1'b1;
      if (cs_sync) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
        skip_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall && armed_q) begin
              state_q <= ST_CMD;
              cnt_q   <= '0;
            end
          end
          ST_CMD: begin
            if (sample_edge) begin
              rx_q <= rx_nxt[RX_W-2:0];
              if (cmd_end) begin
                state_q <= ST_DATA;
                cnt_q   <= '0;
                addr_q  <= cmd_addr;
                wr_q    <= cmd_wr;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (sample_edge) begin
              rx_q <= rx_nxt[RX_W-2:0];
              if (word_end) begin
                cnt_q  <= '0;
                addr_q <= addr_nxt;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (shift_edge && !wr_q) begin
              // CPHA=0 already presented the MSB at load; skip one shift edge
              if (!CPHA && skip_q) begin
                skip_q <= 1'b0;
              end else begin
                miso_q <= tx_q[DATA_W-1];
                tx_q   <= tx_q << 1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
        if (commit) begin
          wr_strobe_q <= 1'b1;
          wr_addr_q   <= addr_q;
        end
        if (do_load) begin
          if (!CPHA) begin
            miso_q <= load_val[DATA_W-1];
            tx_q   <= load_val << 1;
            skip_q <= 1'b1;
          end else begin
            tx_q <= load_val;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign miso      = miso_q;
  assign miso_oe   = ~cs_sync;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
